bram_console_fsm: RTL and testbench
===================================

# bram_console_fsm

Parametrised switch/button console for inspecting and modifying a single-port block RAM from the board. Operator keys an address and optionally a data word in SW_W-bit chunks, MSB first, then reads or writes the addressed word; the current entry or read-back value is presented on a display word for the external hex display mux. The block sits between the button debouncers, the board switches, the BRAM wrapper and the seven-segment mux, replacing fixed 16-bit two-step entry with generic widths, configurable read latency and full-word writes.

## Interface
- SW_W, 16, switch bank width; chunk size for all entry
- ADDR_W, 32, BRAM address width; multiple of SW_W
- DATA_W, 32, BRAM data width; multiple of SW_W and of 8
- READ_LAT, 1, BRAM cycles from en to valid dout; 1..4
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sw  in  SW_W  switch values
- btn_addr, btn_read, btn_write, btn_restart  in  1 each  debounced levels; block edge-detects internally
- bram_dout  in  DATA_W  BRAM read data
- bram_en  out  1  active-high BRAM enable
- bram_we  out  DATA_W/8  byte write enables
- bram_addr  out  ADDR_W  registered address
- bram_din  out  DATA_W  registered write data
- disp_word  out  max(ADDR_W,DATA_W)  value for hex display, zero-extended
- state_o  out  3  current state encoding, for LEDs

## Operation
- Button press = rising edge of the registered level; one action per press, holding does nothing further.
- Same-cycle edges: priority restart > addr > write > read; lower ones dropped.
- ADDR_ENTRY: chunk index k from ADDR_W/SW_W-1 down to 0. disp_word shows entered address with chunk k replaced live by sw. btn_addr latches sw into chunk k; after chunk 0 -> CMD.
- CMD: disp_word = address. btn_read -> READ_WAIT; btn_write -> DATA_ENTRY (k = DATA_W/SW_W-1, data reg cleared); btn_addr -> ADDR_ENTRY at top chunk, address kept.
- READ_WAIT: bram_en=1 on first cycle only; counter runs READ_LAT cycles, then captures bram_dout into read reg -> SHOW.
- SHOW: disp_word = read reg. btn_read re-reads same address (-> READ_WAIT); btn_write -> DATA_ENTRY.
- DATA_ENTRY: same chunk mechanism as address, on data reg, advanced by btn_write. After chunk 0 -> WRITE.
- WRITE: one cycle, bram_en=1, bram_we=all ones, bram_din=data reg; then read reg <= data reg, -> SHOW.
- btn_restart in any state -> ADDR_ENTRY, k = top chunk, address/data/read regs cleared.
- bram_en/bram_we are 0 in every state/cycle not listed above.

## Timing
- Reset: state ADDR_ENTRY, k top, all regs 0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, disp_word=0 except live sw chunk, state_o=0.
- Edge detect adds 1 cycle: level high at cycle n -> action applied at edge n+1, state visible n+2.
- Read: en asserted cycle t; read reg valid and SHOW at t+READ_LAT+1.
- Write: en/we asserted exactly one cycle; no back-to-back writes without operator input.
- Reset mid-read or mid-write: abort, no further en; a write cycle already issued is not undone.

## Configuration
- BRAM_CONSOLE_AUTOINC_EN defined: after each completed read (entering SHOW) or WRITE, address increments by 1 (wraps 2^ADDR_W-1 -> 0); next btn_read reads the next word, enabling memory walk-through.
- Undefined: address held until re-entered via btn_addr or restart.

## Structure
- Package bram_console_pkg: state enum (ADDR_ENTRY, CMD, READ_WAIT, SHOW, DATA_ENTRY, WRITE), state_o encodings, chunk-count helper function.
- Sub-module btn_edge: parametrised N-bit level register plus rising-edge pulse, one instance for the four buttons.

## Test plan
- Defaults: enter 0x0000, 0x0010 via sw+btn_addr, btn_read with bram_dout=0xDEADBEEF -> bram_en one cycle with bram_addr=0x00000010, disp_word=0xDEADBEEF 2 cycles later.
- Write: from CMD, btn_write, enter 0x1234 then 0xABCD -> single cycle bram_we=4'hF, bram_din=0x1234ABCD; disp_word=0x1234ABCD.
- Held button 50 cycles -> exactly one chunk latched; btn_addr+btn_restart same cycle -> restart wins, address 0.
- READ_LAT=3 -> dout sampled exactly 3 cycles after en; changing dout at cycle 2 not captured.
- Reset asserted in READ_WAIT -> bram_en stays 0, state ADDR_ENTRY, disp_word address 0.
- With BRAM_CONSOLE_AUTOINC_EN, address 0xFFFFFFFF, read twice -> second read at address 0x00000000.

Source files
------------

// File: rtl/bram_console_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_console_pkg                                                     |
// | Shared types and helpers for the BRAM switch/button console.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package bram_console_pkg;

   // Values double as the state_o LED encoding.
   typedef enum logic [2:0] {
      ADDR_ENTRY = 3'd0,
      CMD        = 3'd1,
      READ_WAIT  = 3'd2,
      SHOW       = 3'd3,
      DATA_ENTRY = 3'd4,
      WRITE      = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      EV_NONE    = 3'd0,
      EV_RESTART = 3'd1,
      EV_ADDR    = 3'd2,
      EV_WRITE   = 3'd3,
      EV_READ    = 3'd4
   } event_t;

   localparam int c_BTN_READ    = 0;
   localparam int c_BTN_WRITE   = 1;
   localparam int c_BTN_ADDR    = 2;
   localparam int c_BTN_RESTART = 3;

   function automatic int chunk_count(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_console_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_console_fsm_if                                                  |
// | Single-port BRAM bus between the console (master) and the RAM.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface bram_console_fsm_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  bram_en;
   logic [DATA_W/8-1:0]   bram_we;
   logic [ADDR_W-1:0]     bram_addr;
   logic [DATA_W-1:0]     bram_din;
   logic [DATA_W-1:0]     bram_dout;

   modport master (
      output bram_en, bram_we, bram_addr, bram_din,
      input  bram_dout
   );

   modport slave (
      input  bram_en, bram_we, bram_addr, bram_din,
      output bram_dout
   );
endinterface
`default_nettype wire

// File: rtl/bram_console_fsm_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_edge                                                             |
// | Registers N debounced button levels and pulses on each rising edge.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module btn_edge #(
   parameter int N = 4
)(
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic [N-1:0]  i_level,
   output logic [N-1:0]       o_pulse
);
   logic [N-1:0] r_level;
   logic [N-1:0] r_level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_level   <= '0;
         r_level_d <= '0;
      end else begin
         r_level   <= i_level;
         r_level_d <= r_level;
      end
   end

   assign o_pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/bram_console_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_console_fsm                                                     |
// | Switch/button console: key address/data in SW_W chunks, read or     |
// | write one BRAM word, present entry/read-back on disp_word.           |
// | Option macro: BRAM_CONSOLE_AUTOINC_EN (address +1 after read/write). |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bram_console_fsm
   import bram_console_pkg::*;
#(
   parameter  int SW_W     = 16,
   parameter  int ADDR_W   = 32,
   parameter  int DATA_W   = 32,
   parameter  int READ_LAT = 1,
   localparam int DISP_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
)(
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [SW_W-1:0]  sw,
   input  wire logic             btn_addr,
   input  wire logic             btn_read,
   input  wire logic             btn_write,
   input  wire logic             btn_restart,
   bram_console_fsm_if.master    mem,
   output logic [DISP_W-1:0]     disp_word,
   output logic [2:0]            state_o
);
   localparam int c_A_CHUNKS   = chunk_count(ADDR_W, SW_W);
   localparam int c_D_CHUNKS   = chunk_count(DATA_W, SW_W);
   localparam int c_MAX_CHUNKS = (c_A_CHUNKS > c_D_CHUNKS) ? c_A_CHUNKS : c_D_CHUNKS;
   localparam int c_K_W        = $clog2(c_MAX_CHUNKS + 1);
   localparam logic [c_K_W-1:0] c_A_TOP = c_K_W'(c_A_CHUNKS - 1);
   localparam logic [c_K_W-1:0] c_D_TOP = c_K_W'(c_D_CHUNKS - 1);
   localparam logic [2:0]       c_LAT   = 3'(READ_LAT);

   state_t               r_state;
   logic [c_K_W-1:0]     r_k;
   logic [2:0]           r_cnt;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_data;
   logic [DATA_W-1:0]    r_rd;
   logic                 r_en;
   logic [DATA_W/8-1:0]  r_we;

   logic [3:0]           w_pulse;
   event_t               w_ev;
   logic [ADDR_W-1:0]    w_addr_live;
   logic [ADDR_W-1:0]    w_addr_next;
   logic [DATA_W-1:0]    w_data_live;

   btn_edge #(.N(4)) u_btn_edge (
      .clk     (clk),
      .reset   (reset),
      .i_level ({btn_restart, btn_addr, btn_write, btn_read}),
      .o_pulse (w_pulse)
   );

   // One action per cycle; lower-priority simultaneous presses are lost.
   always_comb begin
      w_ev = EV_NONE;
      if (w_pulse[c_BTN_RESTART])    w_ev = EV_RESTART;
      else if (w_pulse[c_BTN_ADDR])  w_ev = EV_ADDR;
      else if (w_pulse[c_BTN_WRITE]) w_ev = EV_WRITE;
      else if (w_pulse[c_BTN_READ])  w_ev = EV_READ;
   end

   always_comb begin
      w_addr_live = r_addr;
      w_addr_live[int'(r_k)*SW_W +: SW_W] = sw;
      w_data_live = r_data;
      w_data_live[int'(r_k)*SW_W +: SW_W] = sw;
   end

`ifdef BRAM_CONSOLE_AUTOINC_EN
   assign w_addr_next = r_addr + ADDR_W'(1);
`else
   assign w_addr_next = r_addr;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ADDR_ENTRY;
         r_k     <= c_A_TOP;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_rd    <= '0;
         r_en    <= 1'b0;
         r_we    <= '0;
      end else begin
         r_en <= 1'b0;
         r_we <= '0;
         if (w_ev == EV_RESTART) begin
            r_state <= ADDR_ENTRY;
            r_k     <= c_A_TOP;
            r_addr  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
         end else begin
            case (r_state)
               ADDR_ENTRY: begin
                  if (w_ev == EV_ADDR) begin
                     r_addr <= w_addr_live;
                     if (r_k == '0) r_state <= CMD;
                     else           r_k     <= r_k - 1'b1;
                  end
               end
               CMD, SHOW: begin
                  if (w_ev == EV_ADDR && r_state == CMD) begin
                     r_state <= ADDR_ENTRY;
                     r_k     <= c_A_TOP;
                  end else if (w_ev == EV_WRITE) begin
                     r_state <= DATA_ENTRY;
                     r_k     <= c_D_TOP;
                     r_data  <= '0;
                  end else if (w_ev == EV_READ) begin
                     r_state <= READ_WAIT;
                     r_cnt   <= '0;
                     r_en    <= 1'b1;
                  end
               end
               READ_WAIT: begin
                  // r_cnt==0 is the enable cycle; dout is valid READ_LAT cycles on.
                  if (r_cnt == c_LAT) begin
                     r_rd    <= mem.bram_dout;
                     r_addr  <= w_addr_next;
                     r_state <= SHOW;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
               DATA_ENTRY: begin
                  if (w_ev == EV_WRITE) begin
                     r_data <= w_data_live;
                     if (r_k == '0) begin
                        r_state <= WRITE;
                        r_en    <= 1'b1;
                        r_we    <= '1;
                     end else begin
                        r_k <= r_k - 1'b1;
                     end
                  end
               end
               WRITE: begin
                  r_rd    <= r_data;
                  r_addr  <= w_addr_next;
                  r_state <= SHOW;
               end
               default: begin
                  r_state <= ADDR_ENTRY;
                  r_k     <= c_A_TOP;
               end
            endcase
         end
      end
   end

   always_comb begin
      disp_word = '0;
      case (r_state)
         ADDR_ENTRY:      disp_word = DISP_W'(w_addr_live);
         CMD, READ_WAIT:  disp_word = DISP_W'(r_addr);
         SHOW:            disp_word = DISP_W'(r_rd);
         DATA_ENTRY:      disp_word = DISP_W'(w_data_live);
         WRITE:           disp_word = DISP_W'(r_data);
         default:         disp_word = '0;
      endcase
   end

   assign state_o       = r_state;
   assign mem.bram_en   = r_en;
   assign mem.bram_we   = r_we;
   assign mem.bram_addr = r_addr;
   assign mem.bram_din  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_bram_console_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_console_fsm                                                  |
// | Two consoles (READ_LAT 1 and 3) on shared keys, each with its own    |
// | RAM model, checked against an operator-level reference.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_bram_console_fsm;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam logic [2:0] S_ADDR = 3'd0, S_CMD = 3'd1, S_DE = 3'd4, S_SHOW = 3'd3;
   localparam int P_ADDR = 0, P_READ = 1, P_WRITE = 2, P_RESTART = 3;

   logic clk = 1'b0;
   logic reset;
   logic [15:0] sw;
   logic btn_addr, btn_read, btn_write, btn_restart;
   logic [31:0] disp_a, disp_b;
   logic [2:0]  st_a, st_b;

   bram_console_fsm_if #(.ADDR_W(32), .DATA_W(32)) mem_a ();
   bram_console_fsm_if #(.ADDR_W(32), .DATA_W(32)) mem_b ();

   bram_console_fsm #(.SW_W(16), .ADDR_W(32), .DATA_W(32), .READ_LAT(LAT_A)) u_dut_a (
      .clk(clk), .reset(reset), .sw(sw), .btn_addr(btn_addr), .btn_read(btn_read),
      .btn_write(btn_write), .btn_restart(btn_restart), .mem(mem_a),
      .disp_word(disp_a), .state_o(st_a));

   bram_console_fsm #(.SW_W(16), .ADDR_W(32), .DATA_W(32), .READ_LAT(LAT_B)) u_dut_b (
      .clk(clk), .reset(reset), .sw(sw), .btn_addr(btn_addr), .btn_read(btn_read),
      .btn_write(btn_write), .btn_restart(btn_restart), .mem(mem_b),
      .disp_word(disp_b), .state_o(st_b));

   always #5 clk = ~clk;

   // Content of a never-written RAM word.
   function automatic logic [31:0] fill(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   // RAM models: dout is valid only in the cycle exactly LAT after en, junk otherwise.
   logic [31:0] env_a [logic [31:0]];
   logic [31:0] env_b [logic [31:0]];
   logic [3:0]  pv_a = '0, pv_b = '0;
   logic [31:0] pd_a [4];
   logic [31:0] pd_b [4];
   logic [31:0] junk = 32'h0;

   always @(posedge clk) begin
      junk <= $urandom;
      pv_a <= {pv_a[2:0], mem_a.bram_en && mem_a.bram_we == 4'h0};
      pv_b <= {pv_b[2:0], mem_b.bram_en && mem_b.bram_we == 4'h0};
      pd_a[0] <= env_a.exists(mem_a.bram_addr) ? env_a[mem_a.bram_addr] : fill(mem_a.bram_addr);
      pd_b[0] <= env_b.exists(mem_b.bram_addr) ? env_b[mem_b.bram_addr] : fill(mem_b.bram_addr);
      for (int i = 1; i < 4; i++) begin
         pd_a[i] <= pd_a[i-1];
         pd_b[i] <= pd_b[i-1];
      end
      if (mem_a.bram_en && mem_a.bram_we == 4'hF) env_a[mem_a.bram_addr] = mem_a.bram_din;
      if (mem_b.bram_en && mem_b.bram_we == 4'hF) env_b[mem_b.bram_addr] = mem_b.bram_din;
   end

   assign mem_a.bram_dout = pv_a[LAT_A-1] ? pd_a[LAT_A-1] : junk;
   assign mem_b.bram_dout = pv_b[LAT_B-1] ? pd_b[LAT_B-1] : junk;

   // Bus activity log per instance (index 0 = a, 1 = b).
   int cyc = 0;
   int en_n[2] = '{0, 0};
   int we_n[2] = '{0, 0};
   int en_cyc[2] = '{0, 0};
   int show_cyc[2] = '{0, 0};
   logic [31:0] en_addr[2], en_din[2];
   logic [3:0]  en_we[2];
   logic [2:0]  st_prev[2] = '{3'd0, 3'd0};

   always @(posedge clk) begin
      if (mem_a.bram_en) begin
         en_n[0]++; en_cyc[0] = cyc; en_addr[0] = mem_a.bram_addr;
         en_we[0] = mem_a.bram_we; en_din[0] = mem_a.bram_din;
         if (mem_a.bram_we != 4'h0) we_n[0]++;
      end
      if (mem_b.bram_en) begin
         en_n[1]++; en_cyc[1] = cyc; en_addr[1] = mem_b.bram_addr;
         en_we[1] = mem_b.bram_we; en_din[1] = mem_b.bram_din;
         if (mem_b.bram_we != 4'h0) we_n[1]++;
      end
      if (st_a == S_SHOW && st_prev[0] != S_SHOW) show_cyc[0] = cyc;
      if (st_b == S_SHOW && st_prev[1] != S_SHOW) show_cyc[1] = cyc;
      st_prev[0] = st_a;
      st_prev[1] = st_b;
      cyc++;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] m_addr;
   logic [31:0] ref_mem [logic [31:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_both(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp);
      check({tag, "_a"}, a, exp);
      check({tag, "_b"}, b, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      btn_addr    = (b == P_ADDR);
      btn_read    = (b == P_READ);
      btn_write   = (b == P_WRITE);
      btn_restart = (b == P_RESTART);
      tick(1);
      {btn_addr, btn_read, btn_write, btn_restart} = 4'b0;
      tick(3);
   endtask

   // Keys val MSB chunk first; checks the live display before each latch.
   task automatic enter(input logic [31:0] val, input logic [31:0] start, input int b);
      logic [31:0] acc, mask, live;
      acc = start;
      for (int k = 1; k >= 0; k--) begin
         sw = val[k*16 +: 16];
         #1;
         mask = 32'hFFFF << (k * 16);
         live = (acc & ~mask) | ({16'h0, sw} << (k * 16));
         chk_both("entry_live", disp_a, disp_b, live);
         acc = live;
         press(b);
      end
   endtask

   task automatic set_addr(input logic [31:0] a);
      press(P_RESTART);
      chk_both("restart_state", st_a, st_b, S_ADDR);
      enter(a, 32'h0, P_ADDR);
      m_addr = a;
      chk_both("addr_state", st_a, st_b, S_CMD);
      chk_both("addr_disp", disp_a, disp_b, a);
   endtask

   task automatic do_read();
      logic [31:0] ea, ed;
      int ca, cb;
      ea = m_addr;
      ed = ref_mem.exists(ea) ? ref_mem[ea] : fill(ea);
      ca = en_n[0]; cb = en_n[1];
      press(P_READ);
      tick(8);
      check("rd_en_cnt_a", en_n[0] - ca, 1);
      check("rd_en_cnt_b", en_n[1] - cb, 1);
      chk_both("rd_addr", en_addr[0], en_addr[1], ea);
      chk_both("rd_we", en_we[0], en_we[1], 4'h0);
      check("rd_lat_a", show_cyc[0] - en_cyc[0], LAT_A + 1);
      check("rd_lat_b", show_cyc[1] - en_cyc[1], LAT_B + 1);
      chk_both("rd_disp", disp_a, disp_b, ed);
      chk_both("rd_state", st_a, st_b, S_SHOW);
`ifdef BRAM_CONSOLE_AUTOINC_EN
      m_addr = m_addr + 32'd1;
`endif
   endtask

   task automatic do_write(input logic [31:0] d);
      logic [31:0] ea;
      int ca, cb, wa, wb;
      ea = m_addr;
      ca = en_n[0]; cb = en_n[1]; wa = we_n[0]; wb = we_n[1];
      press(P_WRITE);
      chk_both("wr_entry_state", st_a, st_b, S_DE);
      enter(d, 32'h0, P_WRITE);
      tick(4);
      check("wr_en_cnt_a", en_n[0] - ca, 1);
      check("wr_en_cnt_b", en_n[1] - cb, 1);
      check("wr_we_cnt_a", we_n[0] - wa, 1);
      check("wr_we_cnt_b", we_n[1] - wb, 1);
      chk_both("wr_we", en_we[0], en_we[1], 4'hF);
      chk_both("wr_addr", en_addr[0], en_addr[1], ea);
      chk_both("wr_din", en_din[0], en_din[1], d);
      chk_both("wr_disp", disp_a, disp_b, d);
      chk_both("wr_state", st_a, st_b, S_SHOW);
      ref_mem[ea] = d;
`ifdef BRAM_CONSOLE_AUTOINC_EN
      m_addr = m_addr + 32'd1;
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] x, y, z;
      logic [31:0] a, d;
      int ca, cb;
      bit got;

      reset = 1'b1; sw = '0;
      {btn_addr, btn_read, btn_write, btn_restart} = 4'b0;
      m_addr = '0;
      tick(4);
      chk_both("rst_state", st_a, st_b, S_ADDR);
      chk_both("rst_en", mem_a.bram_en, mem_b.bram_en, 1'b0);
      chk_both("rst_we", mem_a.bram_we, mem_b.bram_we, 4'h0);
      chk_both("rst_addr", mem_a.bram_addr, mem_b.bram_addr, 32'h0);
      chk_both("rst_din", mem_a.bram_din, mem_b.bram_din, 32'h0);
      chk_both("rst_disp", disp_a, disp_b, 32'h0);
      reset = 1'b0;
      tick(1);
      sw = 16'($urandom);
      #1;
      chk_both("rst_live", disp_a, disp_b, {sw, 16'h0});

      // Directed read of a preloaded word.
      env_a[32'h10] = 32'hDEADBEEF; env_b[32'h10] = 32'hDEADBEEF;
      ref_mem[32'h10] = 32'hDEADBEEF;
      enter(32'h0000_0010, 32'h0, P_ADDR);
      m_addr = 32'h10;
      chk_both("first_addr_state", st_a, st_b, S_CMD);
      do_read();

      // Directed write from CMD, then read it back.
      set_addr(32'h10);
      do_write(32'h1234_ABCD);
      set_addr(32'h10);
      do_read();

      // Held button latches a single chunk.
      press(P_RESTART);
      x = 16'($urandom); y = 16'($urandom);
      sw = x; btn_addr = 1'b1;
      tick(50);
      btn_addr = 1'b0;
      tick(3);
      sw = y;
      #1;
      chk_both("hold_state", st_a, st_b, S_ADDR);
      chk_both("hold_disp", disp_a, disp_b, {x, y});

      // Restart beats addr in the same cycle.
      btn_addr = 1'b1; btn_restart = 1'b1;
      tick(1);
      btn_addr = 1'b0; btn_restart = 1'b0;
      tick(3);
      sw = 16'h0;
      #1;
      chk_both("prio_state", st_a, st_b, S_ADDR);
      chk_both("prio_disp", disp_a, disp_b, 32'h0);
      z = 16'($urandom);
      sw = z;
      #1;
      chk_both("prio_live_top", disp_a, disp_b, {z, 16'h0});

      // Random operator sessions.
      for (int it = 0; it < 12; it++) begin
         if (it % 4 == 0) set_addr($urandom);
         if ($urandom_range(1, 0) == 1) begin
            do_read();
         end else begin
            a = m_addr;
            d = $urandom;
            do_write(d);
            if ($urandom_range(1, 0) == 1) begin
               set_addr(a);
               do_read();
            end
         end
      end

      // Top-of-memory address, read twice.
      set_addr(32'hFFFF_FFFF);
      do_read();
      do_read();

      // Reset while the slower console waits for read data.
      set_addr($urandom);
      sw = 16'h0;
      btn_read = 1'b1;
      tick(1);
      btn_read = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (mem_b.bram_en) got = 1'b1;
         else tick(1);
      end
      check("rw_en_seen", got, 1'b1);
      reset = 1'b1;
      tick(1);
      ca = en_n[0]; cb = en_n[1];
      tick(2);
      reset = 1'b0;
      tick(8);
      check("rw_no_en_a", en_n[0] - ca, 0);
      check("rw_no_en_b", en_n[1] - cb, 0);
      chk_both("rw_state", st_a, st_b, S_ADDR);
      chk_both("rw_disp", disp_a, disp_b, 32'h0);
      m_addr = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
